// File: rtl/rgb_yuv_pkg.sv
// rtl/rgb_yuv_pkg.sv - conversion coefficients and helpers for the RGB to YUV pipeline
package rgb_yuv_pkg;

  localparam int C_YR = 77;
  localparam int C_YG = 150;
  localparam int C_YB = 29;
  localparam int C_UR = 43;
  localparam int C_UG = 84;
  localparam int C_UB = 127;
  localparam int C_VR = 127;
  localparam int C_VG = 106;
  localparam int C_VB = 21;

  localparam int CHROMA_OFS = 128;

  function automatic int rnd_of(input int depth);
    return 1 << (depth - 1);
  endfunction

  // Saturate a shifted/offset component to the 8-bit output range.
  function automatic logic [7:0] sat8(input logic signed [10:0] x);
    if (x[10]) return 8'd0;
    if (x[9:8] != 2'b00) return 8'hFF;
    return x[7:0];
  endfunction

endpackage

// File: rtl/rgb_to_yuv_pixel.sv
// rtl/rgb_to_yuv_pixel.sv - one pixel: product stage, sum/round/shift stage, output clamp
module rgb_to_yuv_pixel
  import rgb_yuv_pkg::*;
#(
  parameter int PIXEL_DEPTH = 10
) (
  input  logic                   clk_i,
  input  logic                   en_i,
  input  logic [PIXEL_DEPTH-1:0] r_i,
  input  logic [PIXEL_DEPTH-1:0] g_i,
  input  logic [PIXEL_DEPTH-1:0] b_i,
  output logic [7:0]             y_o,
  output logic [7:0]             u_o,
  output logic [7:0]             v_o
);

  localparam int S  = PIXEL_DEPTH;
  localparam int PW = S + 8;
  localparam int W  = S + 11;
  localparam logic signed [W-1:0] RND = W'(rnd_of(S));

  function automatic logic [PW-1:0] mul(input logic [S-1:0] x, input int k);
    return PW'(x) * PW'(k);
  endfunction

  function automatic logic signed [W-1:0] sx(input logic [PW-1:0] p);
    return $signed({3'b000, p});
  endfunction

  logic [PW-1:0] p_yr, p_yg, p_yb, p_ur, p_ug, p_ub, p_vr, p_vg, p_vb;
  logic signed [W-1:0] y_sum, u_sum, v_sum;
  logic signed [10:0] y_s2, u_s2, v_s2;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      p_yr <= mul(r_i, C_YR);
      p_yg <= mul(g_i, C_YG);
      p_yb <= mul(b_i, C_YB);
      p_ur <= mul(r_i, C_UR);
      p_ug <= mul(g_i, C_UG);
      p_ub <= mul(b_i, C_UB);
      p_vr <= mul(r_i, C_VR);
      p_vg <= mul(g_i, C_VG);
      p_vb <= mul(b_i, C_VB);
    end
  end

  always_comb begin
    y_sum = sx(p_yr) + sx(p_yg) + sx(p_yb) + RND;
    u_sum = sx(p_ub) - sx(p_ur) - sx(p_ug) + RND;
    v_sum = sx(p_vr) - sx(p_vg) - sx(p_vb) + RND;
  end

  // Chroma may go negative before the offset, hence the arithmetic shift.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      y_s2 <= 11'(y_sum >>> S);
      u_s2 <= 11'(u_sum >>> S) + 11'(CHROMA_OFS);
      v_s2 <= 11'(v_sum >>> S) + 11'(CHROMA_OFS);
    end
  end

  assign y_o = sat8(y_s2);
  assign u_o = sat8(u_s2);
  assign v_o = sat8(v_s2);

endmodule

// File: rtl/rgb_to_yuv_pipe.sv
// rtl/rgb_to_yuv_pipe.sv - three-stage RGB to YUV422/444 converter with ready/valid flow control
module rgb_to_yuv_pipe
  import rgb_yuv_pkg::*;
#(
  parameter int PIXEL_DEPTH   = 10,
  parameter int PIXEL_PER_CLK = 4,
  parameter int OUT_MODE      = 0,
  parameter int CHROMA_AVG    = 0
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [PIXEL_PER_CLK*3*PIXEL_DEPTH-1:0] rgb_i,
  input  logic                                   rgb_valid_i,
  input  logic                                   rgb_last_i,
  output logic                                   rgb_ready_o,
  output logic [PIXEL_PER_CLK*24-1:0]            yuv_o,
  output logic                                   yuv_valid_o,
  output logic                                   yuv_last_o,
  input  logic                                   yuv_ready_i
);

  localparam int S  = PIXEL_DEPTH;
  localparam int P  = PIXEL_PER_CLK;
  localparam int PB = 3 * S;

  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    return 8'(({1'b0, a} + {1'b0, b} + 9'd1) >> 1);
  endfunction

  logic en;
  logic v1, l1, v2, l2;
  logic [7:0] y_c [P];
  logic [7:0] u_c [P];
  logic [7:0] v_c [P];
  logic [P*24-1:0] packed_yuv;

  // Whole pipeline stalls only when the output register holds an unaccepted beat.
  assign en          = !yuv_valid_o || yuv_ready_i;
  assign rgb_ready_o = en;

  for (genvar i = 0; i < P; i++) begin : g_px
    rgb_to_yuv_pixel #(
      .PIXEL_DEPTH(S)
    ) u_px (
      .clk_i(clk_i),
      .en_i (en),
      .r_i  (rgb_i[(P-1-i)*PB + 2*S +: S]),
      .g_i  (rgb_i[(P-1-i)*PB + S +: S]),
      .b_i  (rgb_i[(P-1-i)*PB +: S]),
      .y_o  (y_c[i]),
      .u_o  (u_c[i]),
      .v_o  (v_c[i])
    );
  end

  always_comb begin
    packed_yuv = '0;
    if (OUT_MODE == 1) begin
      for (int n = 0; n < P; n++) begin
        packed_yuv[(P-1-n)*24 +: 24] = {y_c[n], u_c[n], v_c[n]};
      end
    end else begin
      for (int k = 0; k < P/2; k++) begin
        packed_yuv[(P/2-1-k)*32 +: 32] = {
          y_c[2*k],
          (CHROMA_AVG != 0) ? avg8(u_c[2*k], u_c[2*k+1]) : u_c[2*k],
          y_c[2*k+1],
          (CHROMA_AVG != 0) ? avg8(v_c[2*k], v_c[2*k+1]) : v_c[2*k]
        };
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v1          <= 1'b0;
      l1          <= 1'b0;
      v2          <= 1'b0;
      l2          <= 1'b0;
      yuv_valid_o <= 1'b0;
      yuv_last_o  <= 1'b0;
      yuv_o       <= '0;
    end else if (en) begin
      v1          <= rgb_valid_i;
      l1          <= rgb_valid_i && rgb_last_i;
      v2          <= v1;
      l2          <= l1;
      yuv_valid_o <= v2;
      yuv_last_o  <= l2;
      yuv_o       <= packed_yuv;
    end
  end

endmodule

// File: doc/rgb_to_yuv_pipe.md
RGB_TO_YUV_PIPE -- requirements
Module: rgb_to_yuv_pipe

Interface
REQ-001 The block SHALL have parameter PIXEL_DEPTH, default 10, giving bits per colour component (range 8..12).
REQ-002 The block SHALL have parameter PIXEL_PER_CLK, default 4, giving pixels per beat (even, 2..8).
REQ-003 The block SHALL have parameter OUT_MODE, default 0, where 0 selects YUV422 and 1 selects YUV444.
REQ-004 The block SHALL have parameter CHROMA_AVG, default 0, which applies in 422 mode only: 0 keeps the even pixel's U/V, 1 averages the U/V of each pixel pair.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-006 The block SHALL have port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port rgb_i, input, PIXEL_PER_CLK*3*PIXEL_DEPTH bits: pixel 0 in the MSBs, each pixel packed {R,G,B} with R in the MSBs.
REQ-008 The block SHALL have port rgb_valid_i, input, 1 bit: the input beat is valid.
REQ-009 The block SHALL have port rgb_last_i, input, 1 bit: end-of-line sideband, qualified by rgb_valid_i.
REQ-010 The block SHALL have port rgb_ready_o, output, 1 bit: the block accepts the input beat this cycle.
REQ-011 The block SHALL have port yuv_o, output, PIXEL_PER_CLK*24 bits: converted pixels; in 422 mode only the low PIXEL_PER_CLK*16 bits carry data and the upper bits are 0.
REQ-012 The block SHALL have port yuv_valid_o, output, 1 bit: the output beat is valid.
REQ-013 The block SHALL have port yuv_last_o, output, 1 bit: rgb_last_i delayed in alignment with its beat.
REQ-014 The block SHALL have port yuv_ready_i, input, 1 bit: the downstream sink accepts the output beat.

Function
REQ-015 Per-pixel conversion SHALL be as follows, with S=PIXEL_DEPTH and RND=2^(S-1):
- Y = (77R + 150G + 29B + RND) >> S
- U = ((127B - 43R - 84G + RND) >>> S) + 128
- V = ((127R - 106G - 21B + RND) >>> S) + 128
REQ-016 Intermediate sums SHALL be signed and at least S+10 bits wide, and shifts on U/V SHALL be arithmetic.
REQ-017 Y, U and V SHALL each saturate to 0..255; wrap-around is forbidden.
REQ-018 The pipeline SHALL have three register stages:
- S1: products
- S2: sum, round, shift
- S3: clamp, chroma select/average, pack
REQ-019 Latency SHALL be exactly 3 clk_i cycles from input handshake to yuv_valid_o when yuv_ready_i is held high.
REQ-020 Pipeline advance enable SHALL be en = !yuv_valid_o | yuv_ready_i; all stages, including their valid and last bits, SHALL hold when en=0.
REQ-021 rgb_ready_o SHALL equal en, combinationally; a beat is accepted when rgb_valid_i & rgb_ready_o.
REQ-022 yuv_o, yuv_valid_o and yuv_last_o SHALL remain stable while yuv_valid_o=1 and yuv_ready_i=0; no beat SHALL be lost or duplicated.
REQ-023 Pipeline bubbles are not collapsed; a stage with valid=0 SHALL still advance when en=1.
REQ-024 422 packing SHALL pack pair k (pixels 2k, 2k+1) as {Y2k, U, Y2k+1, V}, with pair 0 in the MSBs.
REQ-025 When CHROMA_AVG=1, U and V SHALL each be computed as (C2k + C2k+1 + 1) >> 1 on the clamped 8-bit values.
REQ-026 444 packing SHALL pack pixel n as {Yn, Un, Vn}, with pixel 0 in the MSBs.
REQ-027 With rgb_valid_i=1 and rgb_ready_o=0, the block SHALL not sample rgb_i; the source holds it.
REQ-028 The block SHALL support simultaneous input accept and output drain every cycle, sustaining 1 beat per clock.

Reset
REQ-029 Assertion of reset_n_i=0 SHALL immediately, asynchronously clear all stage valid and last bits and yuv_o to 0.
REQ-030 Data registers other than yuv_o need no reset.
REQ-031 A reset asserted mid-stream SHALL discard all in-flight beats.
REQ-032 After reset deassertion, rgb_ready_o SHALL be 1 and the first accepted beat SHALL emerge 3 cycles later.

Structure
REQ-033 Package rgb_yuv_pkg SHALL hold the nine coefficients, the chroma offset 128, and a function giving RND from PIXEL_DEPTH.
REQ-034 The block SHALL contain one sub-module, rgb_to_yuv_pixel, instantiated PIXEL_PER_CLK times, which implements S1-S2 and the clamp for one pixel with a shared enable.
REQ-035 Packing and chroma averaging SHALL reside in rgb_to_yuv_pipe.

Verification (PIXEL_DEPTH=10, PIXEL_PER_CLK=4)
REQ-036 Bench SHALL cover: all pixels R=G=B=1023, mode 422 -> each pair 0xFF80FF80; Y saturated from 256 to 255.
REQ-037 Bench SHALL cover: all pixels R=1023, G=B=0, mode 444 -> each pixel {0x4D,0x55,0xFF}; with B=1023 instead -> {0x1D,0xFF,0x6B}.
REQ-038 Bench SHALL cover: mode 422, CHROMA_AVG=1, pixel0 red and pixel1 blue (as above) -> pair 0 = {0x4D,0xAA,0x1D,0xB5}; with CHROMA_AVG=0 -> {0x4D,0x55,0x1D,0xFF}.
REQ-039 Bench SHALL cover: 20 back-to-back beats with yuv_ready_i toggling randomly -> output sequence equals input order, rgb_ready_o low exactly when yuv_valid_o & !yuv_ready_i, and yuv_last_o aligned with the beat flagged by rgb_last_i.
REQ-040 Bench SHALL cover: all-zero input -> Y=0x00, U=V=0x80, latency exactly 3 cycles.
REQ-041 Bench SHALL cover: reset_n_i pulsed low for 1 cycle with 3 beats in flight -> yuv_valid_o=0 immediately, no stale beats afterwards, and the next accepted beat appears 3 cycles after acceptance.
